wi_unpack_queue: RTL and testbench

- Buffers 64-byte MRA read-response lines for the active work list (WL).
- Unpacks each line into two work items (WIs) and presents them one at a time to the WI consumer over a valid/ready handshake.
- Sits directly downstream of `mra_controller`:
  - It stores the lines that controller requests.
  - It returns one `FIFO_rd_en` pulse per retired line, which drives that controller's pop accounting.

---
 rtl/wi_unpack_queue.sv | 153 +++++++++++++++
 tb/tb_wi_unpack_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/wi_unpack_queue.sv
// Purpose: buffers MRA response lines and hands out their two WIs one at a time, lower half first.
// Latency: a line pushed at edge N is visible on WI_valid/WI_data in the cycle after edge N.
// Backpressure: WI_ready stalls output with WI_data held; pushes are never stalled (drop+overflow with WI_QUEUE_OVF_CHECK_EN).
module wi_unpack_queue #(
    parameter int LINE_WIDTH     = 512,
    parameter int WL_LEN_BITS    = 32,
    parameter int WI_QUEUE_DEPTH = 20
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [WL_LEN_BITS-1:0]                WL_len,
    input  logic                                  start_dispatch,
    input  logic [LINE_WIDTH-1:0]                 MRA_resp_data,
    input  logic                                  MRA_resp_valid,
    output logic [LINE_WIDTH/2-1:0]               WI_data,
    output logic                                  WI_valid,
    input  logic                                  WI_ready,
    output logic                                  WI_last,
    output logic                                  FIFO_rd_en,
    output logic [$clog2(WI_QUEUE_DEPTH+1)-1:0]   queue_count,
    output logic                                  dispatch_done,
    output logic                                  overflow
);

    localparam int WI_W = LINE_WIDTH / 2;
    localparam int PW   = (WI_QUEUE_DEPTH > 1) ? $clog2(WI_QUEUE_DEPTH) : 1;
    localparam int CW   = $clog2(WI_QUEUE_DEPTH + 1);
    localparam logic [PW-1:0] PTR_MAX = PW'(WI_QUEUE_DEPTH - 1);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    logic [LINE_WIDTH-1:0]  line_mem [WI_QUEUE_DEPTH];

    state_t                 state_q, state_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   half_q, half_d;
    logic [WL_LEN_BITS-1:0] wi_remain_q, wi_remain_d;
    logic                   done_q, done_d;

    logic                   wi_vld, last_wi, hs, retire, push;
    logic [LINE_WIDTH-1:0]  rd_line;

    // Pointer advance with wrap for non power-of-2 depths
    function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PW'(1);
    endfunction

    assign wi_vld  = (state_q == ST_ACTIVE) && (count_q != '0);
    assign last_wi = (wi_remain_q == WL_LEN_BITS'(1));
    assign hs      = wi_vld & WI_ready;
    // A line retires after its upper WI, or early on the WL's final WI (odd tail)
    assign retire  = hs & (half_q | last_wi);

`ifdef WI_QUEUE_OVF_CHECK_EN
    logic full, drop, ovf_q, ovf_d;
    assign full = (count_q == CW'(WI_QUEUE_DEPTH));
    // A retire in the same cycle frees the slot, so a push on full is still legal then
    assign push = MRA_resp_valid & (~full | retire);
    assign drop = MRA_resp_valid & full & ~retire;
    assign ovf_d = ovf_q | drop;

    // Sticky overflow flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end
    assign overflow = ovf_q;

`ifndef SYNTHESIS
    // Flag every dropped line in simulation
    always_ff @(posedge clk) begin
        if (rst_n && drop) $error("wi_unpack_queue: push on full queue dropped");
    end
`endif
`else
    assign push     = MRA_resp_valid;
    assign overflow = 1'b0;
`endif

    assign rd_line     = line_mem[rd_ptr_q];
    assign WI_data     = half_q ? rd_line[LINE_WIDTH-1:WI_W] : rd_line[WI_W-1:0];
    assign WI_valid    = wi_vld;
    assign WI_last     = wi_vld & last_wi;
    assign FIFO_rd_en  = retire;
    assign queue_count = count_q;
    assign dispatch_done = done_q;

    // Next-state for pointers, count, half select and the dispatch FSM
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        half_d      = half_q;
        wi_remain_d = wi_remain_q;
        done_d      = 1'b0;
        if (push)   wr_ptr_d = ptr_nxt(wr_ptr_q);
        if (retire) rd_ptr_d = ptr_nxt(rd_ptr_q);
        count_d = count_q + CW'(push) - CW'(retire);
        case (state_q)
            ST_IDLE: begin
                if (start_dispatch) begin
                    if (WL_len != '0) begin
                        wi_remain_d = WL_len;
                        half_d      = 1'b0;
                        state_d     = ST_ACTIVE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                if (hs) begin
                    wi_remain_d = wi_remain_q - WL_LEN_BITS'(1);
                    half_d      = ~retire;
                    if (last_wi) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state and registered dispatch_done; reset aborts any WL and empties the queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            half_q      <= 1'b0;
            wi_remain_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            half_q      <= half_d;
            wi_remain_q <= wi_remain_d;
            done_q      <= done_d;
        end
    end

    // Line storage, deliberately not reset
    always_ff @(posedge clk) begin
        if (push) line_mem[wr_ptr_q] <= MRA_resp_data;
    end

endmodule

// File: tb/tb_wi_unpack_queue.sv
module tb_wi_unpack_queue;

    logic         clk;
    logic         rst_n;
    logic [31:0]  WL_len;
    logic         start_dispatch;
    logic [511:0] MRA_resp_data;
    logic         MRA_resp_valid;
    logic [255:0] WI_data;
    logic         WI_valid;
    logic         WI_ready;
    logic         WI_last;
    logic         FIFO_rd_en;
    logic [4:0]   queue_count;
    logic         dispatch_done;
    logic         overflow;

    int n_vec = 0;
    int n_err = 0;

    wi_unpack_queue #(.LINE_WIDTH(512), .WL_LEN_BITS(32), .WI_QUEUE_DEPTH(20)) dut (
        .clk(clk), .rst_n(rst_n), .WL_len(WL_len), .start_dispatch(start_dispatch),
        .MRA_resp_data(MRA_resp_data), .MRA_resp_valid(MRA_resp_valid),
        .WI_data(WI_data), .WI_valid(WI_valid), .WI_ready(WI_ready), .WI_last(WI_last),
        .FIFO_rd_en(FIFO_rd_en), .queue_count(queue_count),
        .dispatch_done(dispatch_done), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] lo(input int i);
        logic [31:0] w;
        w = 32'hA000_0000 | 32'(i);
        return {8{w}};
    endfunction

    function automatic logic [255:0] hi(input int i);
        logic [31:0] w;
        w = 32'h5000_0000 | 32'(i);
        return {8{w}};
    endfunction

    function automatic logic [511:0] mk(input int i);
        return {hi(i), lo(i)};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each cycle: drive inputs at negedge, check #1 later (well before the next posedge)
    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; WL_len = '0; start_dispatch = 1'b0;
        MRA_resp_data = '0; MRA_resp_valid = 1'b0; WI_ready = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        #1;
        chk("rst_valid", 256'(WI_valid), 256'(0));
        chk("rst_last", 256'(WI_last), 256'(0));
        chk("rst_rd_en", 256'(FIFO_rd_en), 256'(0));
        chk("rst_done", 256'(dispatch_done), 256'(0));
        chk("rst_ovf", 256'(overflow), 256'(0));
        chk("rst_count", 256'(queue_count), 256'(0));

        // Reset mid-stream
        for (int i = 0; i < 3; i++) begin
            cyc(); MRA_resp_valid = 1'b1; MRA_resp_data = mk(90 + i);
        end
        cyc(); MRA_resp_valid = 1'b0; #1;
        chk("mid_count3", 256'(queue_count), 256'(3));
        chk("mid_idle_valid", 256'(WI_valid), 256'(0));
        cyc(); rst_n = 1'b0; #1;
        chk("mid_rst_count", 256'(queue_count), 256'(0));
        cyc(); rst_n = 1'b1; #1;
        chk("mid_rst_count2", 256'(queue_count), 256'(0));
        chk("mid_rst_valid", 256'(WI_valid), 256'(0));
        chk("mid_rst_ovf", 256'(overflow), 256'(0));

        // Even WL: len 4, lines 0,1
        for (int i = 0; i < 2; i++) begin
            cyc(); MRA_resp_valid = 1'b1; MRA_resp_data = mk(i);
        end
        cyc(); MRA_resp_valid = 1'b0; start_dispatch = 1'b1; WL_len = 32'd4; #1;
        chk("even_idle_valid", 256'(WI_valid), 256'(0));
        cyc(); start_dispatch = 1'b0; WI_ready = 1'b1; #1;
        chk("even_c1_valid", 256'(WI_valid), 256'(1));
        chk("even_c1_data", WI_data, lo(0));
        chk("even_c1_rd", 256'(FIFO_rd_en), 256'(0));
        chk("even_c1_last", 256'(WI_last), 256'(0));
        cyc(); #1;
        chk("even_c2_data", WI_data, hi(0));
        chk("even_c2_rd", 256'(FIFO_rd_en), 256'(1));
        chk("even_c2_last", 256'(WI_last), 256'(0));
        cyc(); #1;
        chk("even_c3_data", WI_data, lo(1));
        chk("even_c3_rd", 256'(FIFO_rd_en), 256'(0));
        chk("even_c3_done", 256'(dispatch_done), 256'(0));
        cyc(); #1;
        chk("even_c4_data", WI_data, hi(1));
        chk("even_c4_rd", 256'(FIFO_rd_en), 256'(1));
        chk("even_c4_last", 256'(WI_last), 256'(1));
        cyc(); WI_ready = 1'b0; #1;
        chk("even_c5_done", 256'(dispatch_done), 256'(1));
        chk("even_c5_valid", 256'(WI_valid), 256'(0));
        chk("even_c5_count", 256'(queue_count), 256'(0));
        cyc(); #1;
        chk("even_c6_done", 256'(dispatch_done), 256'(0));

        // Odd WL: len 3, lines 2,3; upper half of line 3 never appears
        for (int i = 2; i < 4; i++) begin
            cyc(); MRA_resp_valid = 1'b1; MRA_resp_data = mk(i);
        end
        cyc(); MRA_resp_valid = 1'b0; start_dispatch = 1'b1; WL_len = 32'd3; WI_ready = 1'b1;
        cyc(); start_dispatch = 1'b0; #1;
        chk("odd_c1_data", WI_data, lo(2));
        chk("odd_c1_last", 256'(WI_last), 256'(0));
        cyc(); #1;
        chk("odd_c2_data", WI_data, hi(2));
        chk("odd_c2_rd", 256'(FIFO_rd_en), 256'(1));
        cyc(); #1;
        chk("odd_c3_data", WI_data, lo(3));
        chk("odd_c3_last", 256'(WI_last), 256'(1));
        chk("odd_c3_rd", 256'(FIFO_rd_en), 256'(1));
        cyc(); WI_ready = 1'b0; #1;
        chk("odd_c4_done", 256'(dispatch_done), 256'(1));
        chk("odd_c4_valid", 256'(WI_valid), 256'(0));
        chk("odd_c4_count", 256'(queue_count), 256'(0));

        // Backpressure: ready toggles 0/1, each WI held for two cycles
        for (int i = 4; i < 6; i++) begin
            cyc(); MRA_resp_valid = 1'b1; MRA_resp_data = mk(i);
        end
        cyc(); MRA_resp_valid = 1'b0; start_dispatch = 1'b1; WL_len = 32'd4;
        for (int k = 0; k < 8; k++) begin
            cyc(); start_dispatch = 1'b0; WI_ready = k[0]; #1;
            chk("bp_valid", 256'(WI_valid), 256'(1));
            chk("bp_data", WI_data, ((k / 2) % 2 == 1) ? hi(4 + k / 4) : lo(4 + k / 4));
            chk("bp_rd", 256'(FIFO_rd_en), 256'(k == 3 || k == 7));
        end
        cyc(); WI_ready = 1'b0; #1;
        chk("bp_done", 256'(dispatch_done), 256'(1));

        // Full and wrap: rd/wr pointers start at entry 6, fill 20 lines (10..29)
        for (int i = 10; i < 30; i++) begin
            cyc(); MRA_resp_valid = 1'b1; MRA_resp_data = mk(i);
        end
        cyc(); MRA_resp_valid = 1'b0; #1;
        chk("full_count", 256'(queue_count), 256'(20));
`ifdef WI_QUEUE_OVF_CHECK_EN
        cyc(); MRA_resp_valid = 1'b1; MRA_resp_data = mk(99);
        cyc(); MRA_resp_valid = 1'b0; #1;
        chk("ovf_set", 256'(overflow), 256'(1));
        chk("ovf_count", 256'(queue_count), 256'(20));
`endif
        cyc(); start_dispatch = 1'b1; WL_len = 32'd3;
        cyc(); start_dispatch = 1'b0; WI_ready = 1'b1; #1;
        chk("full_c1_data", WI_data, lo(10));
        cyc(); MRA_resp_valid = 1'b1; MRA_resp_data = mk(30); #1;
        chk("full_c2_data", WI_data, hi(10));
        chk("full_c2_rd", 256'(FIFO_rd_en), 256'(1));
        cyc(); MRA_resp_valid = 1'b0; #1;
        chk("full_pushpop_count", 256'(queue_count), 256'(20));
        chk("full_c3_data", WI_data, lo(11));
        chk("full_c3_last", 256'(WI_last), 256'(1));
        cyc(); WI_ready = 1'b0; #1;
        chk("full_c4_count", 256'(queue_count), 256'(19));
        chk("full_c4_done", 256'(dispatch_done), 256'(1));
        // Drain lines 12..30 across both pointer wraps
        cyc(); start_dispatch = 1'b1; WL_len = 32'd38;
        for (int k = 0; k < 38; k++) begin
            cyc(); start_dispatch = 1'b0; WI_ready = 1'b1; #1;
            chk("drain_data", WI_data, (k % 2 == 1) ? hi(12 + k / 2) : lo(12 + k / 2));
        end
        cyc(); WI_ready = 1'b0; #1;
        chk("drain_done", 256'(dispatch_done), 256'(1));
        chk("drain_count", 256'(queue_count), 256'(0));

        // Zero length WL
        cyc(); start_dispatch = 1'b1; WL_len = 32'd0;
        cyc(); start_dispatch = 1'b0; #1;
        chk("zero_done", 256'(dispatch_done), 256'(1));
        chk("zero_valid", 256'(WI_valid), 256'(0));
        cyc(); MRA_resp_valid = 1'b1; MRA_resp_data = mk(40); #1;
        chk("zero_done_clr", 256'(dispatch_done), 256'(0));
        cyc(); MRA_resp_valid = 1'b0; #1;
        chk("zero_idle_valid", 256'(WI_valid), 256'(0));
        chk("zero_idle_count", 256'(queue_count), 256'(1));
        cyc(); start_dispatch = 1'b1; WL_len = 32'd1; WI_ready = 1'b1;
        cyc(); start_dispatch = 1'b0; #1;
        chk("one_data", WI_data, lo(40));
        chk("one_last", 256'(WI_last), 256'(1));
        chk("one_rd", 256'(FIFO_rd_en), 256'(1));
        cyc(); WI_ready = 1'b0; #1;
        chk("one_done", 256'(dispatch_done), 256'(1));
        chk("one_count", 256'(queue_count), 256'(0));
`ifndef WI_QUEUE_OVF_CHECK_EN
        chk("ovf_never", 256'(overflow), 256'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
